sensor_debounce: RTL
====================

Name: sensor_debounce

Overview:
Input conditioning stage directly upstream of the car-park direction FSM. Takes the two raw, asynchronous, bouncy beam-sensor lines (a outer, b inner) from board switches or sensors. Produces synchronised, debounced levels a/b plus single-cycle rise pulses, and feeds them straight into the FSM's a/b inputs. Also flags a stuck/blocked gate condition for the LED status logic.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops per raw input (legal range 2..3)
STABLE_CYCLES, 4, consecutive clock edges a synced value must differ from the debounced output before the output follows (legal 1..255)
CNT_W, 8, width of the per-channel stability counter; must hold STABLE_CYCLES-1
BLOCK_CYCLES, 200, consecutive cycles with a and b both debounced high before fault asserts (legal 1..65535)

Ports:
clk  input  1  system clock; all flops rise-edge
reset  input  1  asynchronous, active-low reset (asserted at 0); clears all state immediately
a_raw  input  1  raw outer sensor, asynchronous to clk
b_raw  input  1  raw inner sensor, asynchronous to clk
a  output  1  debounced outer sensor level, to FSM input a
b  output  1  debounced inner sensor level, to FSM input b
a_rise  output  1  one-cycle pulse, high in the first cycle a reads 1
b_rise  output  1  one-cycle pulse, high in the first cycle b reads 1
fault  output  1  sticky gate-blocked flag

Behaviour:
- Reset (reset=0, async): sync flops, counters, a, b, a_rise, b_rise, fault all 0; channel FSMs in LOW. Mid-operation reset aborts any pending qualification; a pending transition is lost.
- Synchroniser: SYNC_STAGES-flop chain per channel; s = last stage. No logic between stages.
- Per-channel FSM, 4 states:
  - LOW: out=0, cnt=0. If s=1: go CHK_HI with cnt=1, unless STABLE_CYCLES=1, which goes direct to HIGH.
  - CHK_HI: if s=0, back to LOW with cnt=0 (glitch rejected). Else if cnt=STABLE_CYCLES-1, go HIGH and clear cnt. Else cnt+1.
  - HIGH: out=1, cnt=0. If s=0: go CHK_LO with cnt=1, or direct to LOW when STABLE_CYCLES=1.
  - CHK_LO: mirror of CHK_HI.
- Output change on the STABLE_CYCLES-th consecutive edge where s differs from out. Latency from a raw edge, set up before clock edge 1, to the output change is SYNC_STAGES+STABLE_CYCLES edges (defaults: 6).
- Any pulse shorter than STABLE_CYCLES synced cycles produces no output change.
- x_rise: registered alongside x; high exactly one cycle, the cycle x goes 0->1. No fall pulse.
- Channels are independent. Simultaneous transitions on a and b are both honoured in the same cycle.
- Fault: a 16-bit counter increments each cycle a&b=1 and clears when a&b=0. fault sets on the edge the counter reaches BLOCK_CYCLES, stays 1 until reset, and the counter saturates. a/b keep updating while fault=1.
- Counters never wrap. cnt is bounded by STABLE_CYCLES-1.

Optional Feature:
Macro: SENSOR_GLITCH_CNT_EN
- Defined: extra output glitch_cnt, 8 bits, reset 0. It increments by 1, saturating at 255, on every CHK->stable-state return (rejected glitch), counted on either channel. If both channels reject a glitch in the same cycle, it adds 2, saturating.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package carpark_pkg: typedef deb_state_t {LOW, CHK_HI, HIGH, CHK_LO}, default constants for SYNC_STAGES/STABLE_CYCLES/BLOCK_CYCLES, FAULT_CNT_W=16.
- Sub-module debounce_channel (synchroniser + FSM + cnt + rise pulse), instantiated twice.
- Fault counter and optional glitch counter live in the top.

Test Plan:
- Reset: drive reset=0 with a_raw=b_raw=1 -> all outputs 0. Release reset -> a=1 and a_rise=1 exactly 6 edges later (defaults), a_rise=0 the next cycle.
- Glitch: a_raw high for 2 cycles then low -> a stays 0, no a_rise; with SENSOR_GLITCH_CNT_EN, glitch_cnt=1.
- Bounce: a_raw toggles 1,0,1,0,1 at 1-cycle spacing then holds 1 -> a rises only after 4 stable synced cycles, with one a_rise pulse.
- Full car entry sequence a=1; a=1,b=1; b=1; 0 (each held 10 cycles) -> debounced a/b reproduce the sequence, each edge delayed 6 cycles, and the downstream FSM count increments to 1.
- Block: a_raw=b_raw=1 held -> fault=1 on the 200th cycle both debounced high. Drop inputs -> fault stays 1 until reset=0.
- Mid-qualification reset: assert reset during CHK_HI -> a=0 immediately; after release, requalification restarts from LOW.

Source files
------------

// File: rtl/carpark_pkg.sv
// Shared types and default constants for the car-park sensor conditioning path.
package carpark_pkg;

    typedef enum logic [1:0] {
        LOW    = 2'd0,
        CHK_HI = 2'd1,
        HIGH   = 2'd2,
        CHK_LO = 2'd3
    } deb_state_t;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 4;
    localparam int DEF_CNT_W         = 8;
    localparam int DEF_BLOCK_CYCLES  = 200;
    localparam int FAULT_CNT_W       = 16;
    localparam int GLITCH_CNT_W      = 8;

    // Saturating add of up to two single-cycle events onto an 8-bit count.
    function automatic logic [GLITCH_CNT_W-1:0] sat_add_events(
        input logic [GLITCH_CNT_W-1:0] value,
        input logic [1:0]              events
    );
        logic [GLITCH_CNT_W:0] sum;
        sum = {1'b0, value} + (GLITCH_CNT_W+1)'(events[0]) + (GLITCH_CNT_W+1)'(events[1]);
        return sum[GLITCH_CNT_W] ? {GLITCH_CNT_W{1'b1}} : sum[GLITCH_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/sensor_debounce_channel.sv
// One sensor channel: synchroniser chain, 4-state debounce FSM, rise pulse.
// With SENSOR_GLITCH_CNT_EN a rejected-glitch strobe is also exported.
module debounce_channel
    import carpark_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
`ifdef SENSOR_GLITCH_CNT_EN
    output logic glitch,
`endif
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    deb_state_t             state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   level_reg;
    logic                   rise_reg;
    logic                   s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
        end
    end

    assign s = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= LOW;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
        end else begin
            rise_reg <= 1'b0;
            case (state_reg)
                LOW: begin
                    if (s) begin
                        if (STABLE_CYCLES == 1) begin
                            state_reg <= HIGH;
                            level_reg <= 1'b1;
                            rise_reg  <= 1'b1;
                        end else begin
                            state_reg <= CHK_HI;
                            cnt_reg   <= CNT_W'(1);
                        end
                    end
                end
                CHK_HI: begin
                    if (!s) begin
                        state_reg <= LOW;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= HIGH;
                        cnt_reg   <= '0;
                        level_reg <= 1'b1;
                        rise_reg  <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                HIGH: begin
                    if (!s) begin
                        if (STABLE_CYCLES == 1) begin
                            state_reg <= LOW;
                            level_reg <= 1'b0;
                        end else begin
                            state_reg <= CHK_LO;
                            cnt_reg   <= CNT_W'(1);
                        end
                    end
                end
                CHK_LO: begin
                    if (s) begin
                        state_reg <= HIGH;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= LOW;
                        cnt_reg   <= '0;
                        level_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= LOW;
                    cnt_reg   <= '0;
                    level_reg <= 1'b0;
                end
            endcase
        end
    end

`ifdef SENSOR_GLITCH_CNT_EN
    // Strobes on the same edge the FSM falls back to its stable state.
    assign glitch = ((state_reg == CHK_HI) && !s) || ((state_reg == CHK_LO) && s);
`endif

    assign level = level_reg;
    assign rise  = rise_reg;

endmodule

// File: rtl/sensor_debounce.sv
// Two-channel beam-sensor conditioner with sticky gate-blocked fault.
// Optional rejected-glitch counter enabled by SENSOR_GLITCH_CNT_EN.
module sensor_debounce
    import carpark_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int BLOCK_CYCLES  = DEF_BLOCK_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic a_raw,
    input  logic b_raw,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic b_rise,
`ifdef SENSOR_GLITCH_CNT_EN
    output logic [GLITCH_CNT_W-1:0] glitch_cnt,
`endif
    output logic fault
);

    localparam logic [FAULT_CNT_W-1:0] BLOCK_MAX  = FAULT_CNT_W'(BLOCK_CYCLES);
    localparam logic [FAULT_CNT_W-1:0] BLOCK_LAST = FAULT_CNT_W'(BLOCK_CYCLES - 1);

    logic [1:0] raw_vec;
    logic [1:0] level_vec;
    logic [1:0] rise_vec;

    logic [FAULT_CNT_W-1:0] blk_cnt_reg;
    logic                   fault_reg;

    assign raw_vec = {b_raw, a_raw};

`ifdef SENSOR_GLITCH_CNT_EN
    logic [1:0] glitch_vec;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            debounce_channel #(
                .SYNC_STAGES  (SYNC_STAGES),
                .STABLE_CYCLES(STABLE_CYCLES),
                .CNT_W        (CNT_W)
            ) u_chan (
                .clk   (clk),
                .reset (reset),
                .raw   (raw_vec[gi]),
`ifdef SENSOR_GLITCH_CNT_EN
                .glitch(glitch_vec[gi]),
`endif
                .level (level_vec[gi]),
                .rise  (rise_vec[gi])
            );
        end
    endgenerate

    // Counter holds at BLOCK_CYCLES once reached; fault is cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blk_cnt_reg <= '0;
            fault_reg   <= 1'b0;
        end else if (level_vec[0] && level_vec[1]) begin
            if (blk_cnt_reg != BLOCK_MAX) begin
                blk_cnt_reg <= blk_cnt_reg + 1'b1;
            end
            if (blk_cnt_reg == BLOCK_LAST) begin
                fault_reg <= 1'b1;
            end
        end else begin
            blk_cnt_reg <= '0;
        end
    end

`ifdef SENSOR_GLITCH_CNT_EN
    logic [GLITCH_CNT_W-1:0] glitch_cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            glitch_cnt_reg <= '0;
        end else begin
            glitch_cnt_reg <= sat_add_events(glitch_cnt_reg, glitch_vec);
        end
    end

    assign glitch_cnt = glitch_cnt_reg;
`endif

    assign a      = level_vec[0];
    assign b      = level_vec[1];
    assign a_rise = rise_vec[0];
    assign b_rise = rise_vec[1];
    assign fault  = fault_reg;

endmodule
